// File: rtl/sys_defs.sv
// Shared issue-stage types and sizing macros; `RS_SZ and `N may be overridden on the command line.
// Optional statistics counters in rs_issue_select are enabled with ISSUE_STATS_EN.
`ifndef RS_SZ
`define RS_SZ 16
`endif
`ifndef N
`define N 3
`endif

package sys_defs;

  localparam int RS_SZ_DEF = `RS_SZ;
  localparam int N_DEF     = `N;

  typedef logic [$clog2(`RS_SZ)-1:0] RS_IDX;

  typedef struct packed {
    logic [31:0] opa;
    logic [31:0] opb;
    logic [4:0]  dest_preg;
    logic [5:0]  rob_idx;
    logic [3:0]  fu_op;
  } RS_EXIT_PACKET;

endpackage

// File: rtl/rr_select_n.sv
// Rotating-priority picker: grants up to max_grants requests, scanning upward from ptr with wrap.
module rr_select_n
  import sys_defs::*;
#(
  parameter int RS_SZ = `RS_SZ,
  parameter int N     = `N,
  localparam int IDX_W = $clog2(RS_SZ),
  localparam int CW    = $clog2(N + 1)
) (
  input  logic [RS_SZ-1:0]        req,
  input  logic [IDX_W-1:0]        ptr,
  input  logic [CW-1:0]           max_grants,
  output logic [RS_SZ-1:0]        grant_mask,
  output logic [N-1:0][IDX_W-1:0] grant_idx,
  output logic [N-1:0]            grant_vld,
  output logic [IDX_W-1:0]        last_idx
);

  logic [IDX_W:0]   pos;
  logic [IDX_W-1:0] idx;
  logic [CW-1:0]    cnt;

  // Wrap by explicit compare so RS_SZ need not be a power of two.
  always_comb begin
    grant_mask = '0;
    grant_idx  = '0;
    grant_vld  = '0;
    last_idx   = ptr;
    cnt        = '0;
    pos        = '0;
    idx        = '0;
    for (int off = 0; off < RS_SZ; off++) begin
      pos = {1'b0, ptr} + (IDX_W+1)'(off);
      if (pos >= (IDX_W+1)'(RS_SZ)) pos = pos - (IDX_W+1)'(RS_SZ);
      idx = pos[IDX_W-1:0];
      if (req[idx] && (cnt < max_grants)) begin
        grant_mask[idx] = 1'b1;
        for (int k = 0; k < N; k++) begin
          if (cnt == CW'(k)) begin
            grant_idx[k] = idx;
            grant_vld[k] = 1'b1;
          end
        end
        last_idx = idx;
        cnt      = cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/rs_issue_select.sv
// Issue stage behind the reservation station: picks ready entries into N lane registers.
// Define ISSUE_STATS_EN to add the stat_issued / stat_stall_cycles counters.
module rs_issue_select
  import sys_defs::*;
#(
  parameter int RS_SZ = `RS_SZ,
  parameter int N     = `N
) (
  input  logic                       clock,
  input  logic                       reset,
  input  RS_EXIT_PACKET [RS_SZ-1:0]  rs_outputs,
  input  logic [RS_SZ-1:0]           outputs_valid,
  input  logic [N-1:0]               fu_ready,
  input  logic                       flush,
  output RS_EXIT_PACKET [N-1:0]      issue_packets,
  output logic [N-1:0]               issue_valid,
  output logic [RS_SZ-1:0]           rs_clear
`ifdef ISSUE_STATS_EN
  ,
  output logic [31:0]                stat_issued,
  output logic [31:0]                stat_stall_cycles
`endif
);

  localparam int IDX_W = $clog2(RS_SZ);
  localparam int CW    = $clog2(N + 1);

  RS_EXIT_PACKET [N-1:0]   pkt_q, pkt_d;
  logic [N-1:0]            vld_q, vld_d;
  logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [N-1:0]            lane_free;
  logic [CW-1:0]           free_cnt, max_grants, slot;
  logic [RS_SZ-1:0]        grant_mask;
  logic [N-1:0][IDX_W-1:0] grant_idx;
  logic [N-1:0]            grant_vld;
  logic [IDX_W-1:0]        last_idx;

  always_comb begin
    lane_free = ~vld_q | fu_ready;
    free_cnt  = '0;
    for (int k = 0; k < N; k++) free_cnt = free_cnt + CW'(lane_free[k]);
    max_grants = flush ? '0 : free_cnt;
  end

  rr_select_n #(.RS_SZ(RS_SZ), .N(N)) u_select (
    .req        (outputs_valid),
    .ptr        (rr_ptr_q),
    .max_grants (max_grants),
    .grant_mask (grant_mask),
    .grant_idx  (grant_idx),
    .grant_vld  (grant_vld),
    .last_idx   (last_idx)
  );

  assign rs_clear = reset ? grant_mask : '0;

  // The j-th grant lands in the j-th free lane counting upward from lane 0.
  always_comb begin
    pkt_d = pkt_q;
    vld_d = vld_q;
    slot  = '0;
    for (int k = 0; k < N; k++) begin
      if (lane_free[k]) begin
        vld_d[k] = 1'b0;
        for (int j = 0; j < N; j++) begin
          if ((slot == CW'(j)) && grant_vld[j]) begin
            vld_d[k] = 1'b1;
            pkt_d[k] = rs_outputs[grant_idx[j]];
          end
        end
        slot = slot + CW'(1);
      end
    end
    if (flush) vld_d = '0;
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (flush) rr_ptr_d = '0;
    else if (|grant_vld)
      rr_ptr_d = (last_idx == IDX_W'(RS_SZ - 1)) ? '0 : last_idx + IDX_W'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pkt_q    <= '0;
      vld_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      pkt_q    <= pkt_d;
      vld_q    <= vld_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign issue_packets = pkt_q;
  assign issue_valid   = vld_q;

`ifdef ISSUE_STATS_EN
  logic [31:0]   issued_q, issued_d, stall_q, stall_d;
  logic [CW-1:0] fire_cnt;
  logic [32:0]   issued_sum;

  // Both counters saturate rather than wrap.
  always_comb begin
    fire_cnt = '0;
    for (int k = 0; k < N; k++) fire_cnt = fire_cnt + CW'(vld_q[k] & fu_ready[k]);
    issued_sum = {1'b0, issued_q} + 33'(fire_cnt);
    issued_d   = issued_sum[32] ? '1 : issued_sum[31:0];
    stall_d    = stall_q;
    if ((|(vld_q & ~fu_ready)) && (stall_q != '1)) stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      issued_q <= '0;
      stall_q  <= '0;
    end else begin
      issued_q <= issued_d;
      stall_q  <= stall_d;
    end
  end

  assign stat_issued       = issued_q;
  assign stat_stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_rs_issue_select.sv
// Directed self-checking bench for rs_issue_select with hand-computed expectations (RS_SZ=16, N=3).
module tb_rs_issue_select;
  import sys_defs::*;

  logic                  clock;
  logic                  reset;
  RS_EXIT_PACKET [15:0]  rs_outputs;
  logic [15:0]           outputs_valid;
  logic [2:0]            fu_ready;
  logic                  flush;
  RS_EXIT_PACKET [2:0]   issue_packets;
  logic [2:0]            issue_valid;
  logic [15:0]           rs_clear;
`ifdef ISSUE_STATS_EN
  logic [31:0]           stat_issued;
  logic [31:0]           stat_stall_cycles;
`endif

  int checkCount = 0;
  int failCount  = 0;

  rs_issue_select dut (
    .clock         (clock),
    .reset         (reset),
    .rs_outputs    (rs_outputs),
    .outputs_valid (outputs_valid),
    .fu_ready      (fu_ready),
    .flush         (flush),
    .issue_packets (issue_packets),
    .issue_valid   (issue_valid),
    .rs_clear      (rs_clear)
`ifdef ISSUE_STATS_EN
    ,
    .stat_issued       (stat_issued),
    .stat_stall_cycles (stat_stall_cycles)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkLane(input string tag, input int k, input int entry);
    checkOutput(tag, 64'(issue_packets[k].opa), 64'(32'hA000_0000 + entry));
  endtask

  task automatic applyStimulus(input logic [15:0] ready, input logic [2:0] fr, input logic fl);
    outputs_valid = ready;
    fu_ready      = fr;
    flush         = fl;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      rs_outputs[i].opa       = 32'hA000_0000 + i;
      rs_outputs[i].opb       = 32'hB000_0000 + i;
      rs_outputs[i].dest_preg = 5'(i);
      rs_outputs[i].rob_idx   = 6'(i + 32);
      rs_outputs[i].fu_op     = 4'(i);
    end
    reset = 1'b1;
    applyStimulus(16'h0000, 3'b000, 1'b0);
    #2 reset = 1'b0;
    applyStimulus(16'hFFFF, 3'b111, 1'b0);
    tick();
    tick();
    checkOutput("rst_valid", 64'(issue_valid), 64'h0);
    checkOutput("rst_clear", 64'(rs_clear), 64'h0);

    reset = 1'b1;
    #1 checkOutput("rel_clear", 64'(rs_clear), 64'h0007);
    tick();
    checkOutput("rel_valid", 64'(issue_valid), 64'h7);
    checkLane("rel_lane2", 2, 2);
    checkOutput("rel_clear2", 64'(rs_clear), 64'h0038);

    #4 reset = 1'b0;
    #1;
    checkOutput("midrst_valid", 64'(issue_valid), 64'h0);
    checkOutput("midrst_clear", 64'(rs_clear), 64'h0);
    tick();
    reset = 1'b1;
    applyStimulus(16'h0016, 3'b111, 1'b0);
    #1 checkOutput("basic_clear", 64'(rs_clear), 64'h0016);
    tick();
    checkOutput("basic_valid", 64'(issue_valid), 64'h7);
    checkLane("basic_lane0", 0, 1);
    checkLane("basic_lane1", 1, 2);
    checkLane("basic_lane2", 2, 4);

    applyStimulus(16'h00F0, 3'b111, 1'b0);
    #1 checkOutput("ptr5_clear", 64'(rs_clear), 64'h00E0);
    tick();
    checkLane("ptr5_lane0", 0, 5);
    checkLane("ptr5_lane2", 2, 7);

    applyStimulus(16'h2000, 3'b111, 1'b0);
    #1 checkOutput("few_clear", 64'(rs_clear), 64'h2000);
    tick();
    checkOutput("few_valid", 64'(issue_valid), 64'h1);
    checkLane("few_lane0", 0, 13);

    applyStimulus(16'h8209, 3'b111, 1'b0);
    #1 checkOutput("wrap_clear", 64'(rs_clear), 64'h8009);
    tick();
    checkOutput("wrap_valid", 64'(issue_valid), 64'h7);
    checkLane("wrap_lane0", 0, 15);
    checkLane("wrap_lane1", 1, 0);
    checkLane("wrap_lane2", 2, 3);

    applyStimulus(16'h0202, 3'b111, 1'b0);
    #1 checkOutput("ptr4_clear", 64'(rs_clear), 64'h0202);
    tick();
    checkOutput("ptr4_valid", 64'(issue_valid), 64'h3);
    checkLane("ptr4_lane0", 0, 9);
    checkLane("ptr4_lane1", 1, 1);

    applyStimulus(16'h0044, 3'b101, 1'b0);
    #1 checkOutput("bp_clear", 64'(rs_clear), 64'h0044);
    tick();
    checkOutput("bp_valid", 64'(issue_valid), 64'h7);
    checkLane("bp_lane0", 0, 2);
    checkLane("bp_lane1", 1, 1);
    checkLane("bp_lane2", 2, 6);

    applyStimulus(16'hFFFF, 3'b000, 1'b0);
    #1 checkOutput("stall_clear0", 64'(rs_clear), 64'h0);
    for (int c = 0; c < 5; c++) begin
      tick();
      checkOutput("stall_valid", 64'(issue_valid), 64'h7);
      checkOutput("stall_clear", 64'(rs_clear), 64'h0);
      checkLane("stall_lane0", 0, 2);
      checkLane("stall_lane1", 1, 1);
      checkLane("stall_lane2", 2, 6);
    end

    applyStimulus(16'hFFFF, 3'b001, 1'b0);
    #1 checkOutput("ptr7_clear", 64'(rs_clear), 64'h0080);
    applyStimulus(16'hFFFF, 3'b001, 1'b1);
    #1 checkOutput("flush_clear", 64'(rs_clear), 64'h0);
    tick();
    applyStimulus(16'hFFFF, 3'b111, 1'b0);
    checkOutput("flush_valid", 64'(issue_valid), 64'h0);
`ifdef ISSUE_STATS_EN
    checkOutput("stat_stall", 64'(stat_stall_cycles), 64'd7);
    checkOutput("stat_issued", 64'(stat_issued), 64'd12);
`endif
    #1 checkOutput("ptr0_clear", 64'(rs_clear), 64'h0007);
    tick();
    checkOutput("post_valid", 64'(issue_valid), 64'h7);
    checkLane("post_lane0", 0, 0);
    checkLane("post_lane2", 2, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
